// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer and its consumers.
//   sal_t       : per-entry result broadcast {tag, rdy, data}, the same
//                 layout the register file reads for forwarding/writeback.
//   rob_entry_t : one reorder-buffer slot {valid, rdy, rd, data}.
package reorder_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } sal_t;

  typedef struct packed {
    logic              valid;
    logic              rdy;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of reorder-buffer signals: issue-side allocation, CDB writeback,
// flush, per-entry broadcast and in-order commit.
//   master : issue stage / CDB / pipeline control (drives alloc, cdb, flush)
//   slave  : the reorder buffer itself
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int width = DATA_W,
  parameter int size  = 8
) ();

  logic                  alloc_valid;
  logic [RD_W-1:0]       alloc_rd;
  logic                  alloc_ready;
  logic [TAG_W-1:0]      alloc_tag;

  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [width-1:0]      cdb_data;

  logic                  flush;

  sal_t                  rdest  [size];
  logic [RD_W-1:0]       rd_bus [size];

  logic                  commit_valid;
  logic [RD_W-1:0]       commit_rd;
  logic [width-1:0]      commit_data;
  logic [TAG_W-1:0]      commit_tag;

  logic [$clog2(size):0] count;

  modport master (
    output alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, flush,
    input  alloc_ready, alloc_tag, rdest, rd_bus,
           commit_valid, commit_rd, commit_data, commit_tag, count
  );

  modport slave (
    input  alloc_valid, alloc_rd, cdb_valid, cdb_tag, cdb_data, flush,
    output alloc_ready, alloc_tag, rdest, rd_bus,
           commit_valid, commit_rd, commit_data, commit_tag, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order reorder buffer. Allocates a tag (the tail index) per issued
// instruction, accepts out-of-order results from the CDB, broadcasts every
// entry to the register file and retires the head entry once it is ready.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   rob      : reorder_buffer_if.slave (alloc_*, cdb_*, flush, rdest,
//              rd_bus, commit_*, count)
// size must be a power of two between 2 and 16 so the pointers wrap by
// plain overflow; width may not exceed 32 because sal_t carries 32 bits.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int width = DATA_W,
  parameter int size  = 8
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave rob
);

  localparam int IDX_W = $clog2(size);
  localparam int CNT_W = IDX_W + 1;

  rob_entry_t       entry_q [size];
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  rob_entry_t       head_e;
  logic [IDX_W-1:0] cdb_idx;
  logic             cdb_in_range;
  logic             full;
  logic             do_alloc;
  logic             do_wb;
  logic             do_commit;

  always_comb begin
    head_e       = entry_q[head_q];
    cdb_idx      = rob.cdb_tag[IDX_W-1:0];
    // Tags beyond the array are treated like unallocated entries.
    cdb_in_range = (int'(rob.cdb_tag) < size);
    // Full blocks allocation even when the head retires this cycle.
    full         = (count_q == CNT_W'(size));
    do_alloc     = rob.alloc_valid && !full && !rob.flush;
    do_wb        = rob.cdb_valid && cdb_in_range && entry_q[cdb_idx].valid &&
                   !entry_q[cdb_idx].rdy && !rob.flush;
    do_commit    = head_e.valid && head_e.rdy && !rob.flush;
  end

  // Allocate, writeback and commit never target the same slot in one cycle:
  // allocate needs an invalid slot, writeback a valid non-ready one and
  // commit a valid ready one.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < size; i++) begin
        entry_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rob.flush) begin
      for (int i = 0; i < size; i++) begin
        entry_q[i].valid <= 1'b0;
        entry_q[i].rdy   <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wb) begin
        entry_q[cdb_idx].data <= DATA_W'(rob.cdb_data);
        entry_q[cdb_idx].rdy  <= 1'b1;
      end
      if (do_commit) begin
        entry_q[head_q].valid <= 1'b0;
        entry_q[head_q].rdy   <= 1'b0;
        head_q                <= head_q + IDX_W'(1);
      end
      if (do_alloc) begin
        entry_q[tail_q] <= '{valid: 1'b1, rdy: 1'b0, rd: rob.alloc_rd, data: '0};
        tail_q          <= tail_q + IDX_W'(1);
      end
      count_q <= count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);
    end
  end

  always_comb begin
    rob.alloc_ready  = !full;
    rob.alloc_tag    = TAG_W'(tail_q);
    rob.count        = count_q;
    rob.commit_valid = do_commit;
    rob.commit_rd    = head_e.rd;
    rob.commit_data  = head_e.data[width-1:0];
    rob.commit_tag   = TAG_W'(head_q);
    for (int i = 0; i < size; i++) begin
      rob.rdest[i]  = '{tag:  TAG_W'(i),
                        rdy:  entry_q[i].valid && entry_q[i].rdy,
                        data: entry_q[i].data};
      rob.rd_bus[i] = entry_q[i].valid ? entry_q[i].rd : '0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a
// randomized run compared against a program-order queue model.
module tb_reorder_buffer;

  localparam int SIZE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.width(32), .size(SIZE)) dut_if ();

  reorder_buffer #(.width(32), .size(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .rob (dut_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Inputs as last driven by the bench.
  bit          in_av, in_cv, in_fl;
  logic [4:0]  in_rd;
  logic [3:0]  in_ct;
  logic [31:0] in_cd;

  // Reference model: outstanding tags in program order plus per-tag info.
  int          q_tag[$];
  bit          m_busy  [16];
  bit          m_ready [16];
  logic [4:0]  m_rd    [16];
  logic [31:0] m_data  [16];
  int          next_tag;

  task automatic set_in(input bit av, input logic [4:0] rd, input bit cv,
                        input logic [3:0] ct, input logic [31:0] cd, input bit fl);
    in_av = av; in_rd = rd; in_cv = cv; in_ct = ct; in_cd = cd; in_fl = fl;
    dut_if.alloc_valid = av;
    dut_if.alloc_rd    = rd;
    dut_if.cdb_valid   = cv;
    dut_if.cdb_tag     = ct;
    dut_if.cdb_data    = cd;
    dut_if.flush       = fl;
  endtask

  task automatic model_edge();
    bit commit, alloc, wb;
    int t;
    if (rst) begin
      q_tag.delete();
      for (int i = 0; i < 16; i++) begin
        m_busy[i] = 0; m_ready[i] = 0; m_rd[i] = '0; m_data[i] = '0;
      end
      next_tag = 0;
    end else if (in_fl) begin
      q_tag.delete();
      for (int i = 0; i < 16; i++) begin
        m_busy[i] = 0; m_ready[i] = 0;
      end
      next_tag = 0;
    end else begin
      commit = (q_tag.size() > 0) && m_ready[q_tag[0]];
      alloc  = in_av && (q_tag.size() < SIZE);
      wb     = in_cv && m_busy[in_ct] && !m_ready[in_ct];
      if (wb) begin
        m_data[in_ct]  = in_cd;
        m_ready[in_ct] = 1;
      end
      if (commit) begin
        t = q_tag.pop_front();
        m_busy[t]  = 0;
        m_ready[t] = 0;
      end
      if (alloc) begin
        m_busy[next_tag]  = 1;
        m_ready[next_tag] = 0;
        m_rd[next_tag]    = in_rd;
        m_data[next_tag]  = '0;
        q_tag.push_back(next_tag);
        next_tag = (next_tag + 1) % SIZE;
      end
    end
  endtask

  // One clock: update model, cross the edge, return to idle inputs.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    set_in(0, 5'd0, 0, 4'd0, 32'd0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests_run++; if (dut_if.count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", dut_if.count); end
    tests_run++; if (dut_if.alloc_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_alloc_ready: got %b want 1", dut_if.alloc_ready); end
    tests_run++; if (dut_if.alloc_tag !== 4'd0) begin tests_failed++; $display("FAIL reset_alloc_tag: got %0d want 0", dut_if.alloc_tag); end
    tests_run++; if (dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_commit_valid: got %b want 0", dut_if.commit_valid); end
    for (int i = 0; i < SIZE; i++) begin
      tests_run++;
      if (dut_if.rdest[i].tag !== 4'(i) || dut_if.rdest[i].rdy !== 1'b0 ||
          dut_if.rdest[i].data !== 32'd0 || dut_if.rd_bus[i] !== 5'd0) begin
        tests_failed++;
        $display("FAIL reset_entry%0d: got tag=%0d rdy=%b data=%h rd=%0d want tag=%0d rdy=0 data=0 rd=0",
                 i, dut_if.rdest[i].tag, dut_if.rdest[i].rdy, dut_if.rdest[i].data, dut_if.rd_bus[i], i);
      end
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_in(1, 5'd3, 0, 4'd0, 32'd0, 0); tick();
    set_in(1, 5'd4, 1, 4'd0, 32'h1234, 0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    tests_run++; if (dut_if.count !== 4'd0) begin tests_failed++; $display("FAIL midrst_count: got %0d want 0", dut_if.count); end
    tests_run++; if (dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_commit_valid: got %b want 0", dut_if.commit_valid); end
    tests_run++; if (dut_if.rdest[0].data !== 32'd0 || dut_if.rd_bus[1] !== 5'd0) begin tests_failed++; $display("FAIL midrst_entries: got data0=%h rd1=%0d want 0 0", dut_if.rdest[0].data, dut_if.rd_bus[1]); end
    tick(); #1;
    tests_run++; if (dut_if.count !== 4'd0 || dut_if.alloc_tag !== 4'd0) begin tests_failed++; $display("FAIL midrst_settled: got count=%0d tag=%0d want 0 0", dut_if.count, dut_if.alloc_tag); end
  endtask

  task automatic test_single();
    do_reset();
    set_in(1, 5'd5, 0, 4'd0, 32'd0, 0); tick(); #1;
    tests_run++; if (dut_if.rd_bus[0] !== 5'd5) begin tests_failed++; $display("FAIL single_rd_bus: got %0d want 5", dut_if.rd_bus[0]); end
    tests_run++; if (dut_if.alloc_tag !== 4'd1 || dut_if.count !== 4'd1) begin tests_failed++; $display("FAIL single_alloc: got tag=%0d count=%0d want 1 1", dut_if.alloc_tag, dut_if.count); end
    tests_run++; if (dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_commit: got %b want 0", dut_if.commit_valid); end
    set_in(0, 5'd0, 1, 4'd0, 32'hDEADBEEF, 0); tick(); #1;
    tests_run++; if (dut_if.rdest[0].rdy !== 1'b1) begin tests_failed++; $display("FAIL single_rdy: got %b want 1", dut_if.rdest[0].rdy); end
    tests_run++; if (dut_if.commit_valid !== 1'b1) begin tests_failed++; $display("FAIL single_commit_valid: got %b want 1", dut_if.commit_valid); end
    tests_run++; if (dut_if.commit_rd !== 5'd5 || dut_if.commit_data !== 32'hDEADBEEF || dut_if.commit_tag !== 4'd0) begin
      tests_failed++; $display("FAIL single_commit_fields: got rd=%0d data=%h tag=%0d want 5 deadbeef 0", dut_if.commit_rd, dut_if.commit_data, dut_if.commit_tag); end
    tick(); #1;
    tests_run++; if (dut_if.count !== 4'd0 || dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL single_retired: got count=%0d cv=%b want 0 0", dut_if.count, dut_if.commit_valid); end
  endtask

  task automatic test_out_of_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(i + 1), 0, 4'd0, 32'd0, 0); tick();
    end
    for (int t = 2; t >= 1; t--) begin
      set_in(0, 5'd0, 1, 4'(t), 32'h100 + 32'(t), 0); tick(); #1;
      tests_run++; if (dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL ooo_no_commit_t%0d: got %b want 0", t, dut_if.commit_valid); end
    end
    set_in(0, 5'd0, 1, 4'd0, 32'h100, 0); tick(); #1;
    for (int t = 0; t < 3; t++) begin
      tests_run++;
      if (dut_if.commit_valid !== 1'b1 || dut_if.commit_tag !== 4'(t) ||
          dut_if.commit_rd !== 5'(t + 1) || dut_if.commit_data !== 32'h100 + 32'(t)) begin
        tests_failed++;
        $display("FAIL ooo_commit%0d: got cv=%b tag=%0d rd=%0d data=%h want 1 %0d %0d %h",
                 t, dut_if.commit_valid, dut_if.commit_tag, dut_if.commit_rd, dut_if.commit_data, t, t + 1, 32'h100 + 32'(t));
      end
      tick(); #1;
    end
    tests_run++; if (dut_if.commit_valid !== 1'b0 || dut_if.count !== 4'd0) begin tests_failed++; $display("FAIL ooo_drained: got cv=%b count=%0d want 0 0", dut_if.commit_valid, dut_if.count); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < SIZE; i++) begin
      set_in(1, 5'(i + 1), 0, 4'd0, 32'd0, 0); tick();
    end
    #1;
    tests_run++; if (dut_if.count !== 4'd8 || dut_if.alloc_ready !== 1'b0 || dut_if.alloc_tag !== 4'd0) begin
      tests_failed++; $display("FAIL full_state: got count=%0d ready=%b tag=%0d want 8 0 0", dut_if.count, dut_if.alloc_ready, dut_if.alloc_tag); end
    set_in(1, 5'd20, 0, 4'd0, 32'd0, 0); tick(); #1;
    tests_run++; if (dut_if.count !== 4'd8 || dut_if.rd_bus[0] !== 5'd1) begin
      tests_failed++; $display("FAIL full_drop: got count=%0d rd0=%0d want 8 1", dut_if.count, dut_if.rd_bus[0]); end
    set_in(0, 5'd0, 1, 4'd0, 32'h55, 0); tick();
    set_in(1, 5'd9, 0, 4'd0, 32'd0, 0); #1;
    tests_run++; if (dut_if.commit_valid !== 1'b1 || dut_if.commit_tag !== 4'd0 || dut_if.alloc_ready !== 1'b0) begin
      tests_failed++; $display("FAIL full_commit: got cv=%b tag=%0d ready=%b want 1 0 0", dut_if.commit_valid, dut_if.commit_tag, dut_if.alloc_ready); end
    tick(); #1;
    tests_run++; if (dut_if.count !== 4'd7 || dut_if.alloc_ready !== 1'b1 || dut_if.rd_bus[0] !== 5'd0) begin
      tests_failed++; $display("FAIL full_freed: got count=%0d ready=%b rd0=%0d want 7 1 0", dut_if.count, dut_if.alloc_ready, dut_if.rd_bus[0]); end
    set_in(1, 5'd9, 0, 4'd0, 32'd0, 0); tick(); #1;
    tests_run++; if (dut_if.rd_bus[0] !== 5'd9 || dut_if.count !== 4'd8 || dut_if.alloc_tag !== 4'd1 || dut_if.rd_bus[1] !== 5'd2) begin
      tests_failed++; $display("FAIL wrap_alloc: got rd0=%0d count=%0d tag=%0d rd1=%0d want 9 8 1 2", dut_if.rd_bus[0], dut_if.count, dut_if.alloc_tag, dut_if.rd_bus[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5'(i + 4), 0, 4'd0, 32'd0, 0); tick();
    end
    set_in(0, 5'd0, 1, 4'd0, 32'h77, 0); tick(); #1;
    tests_run++; if (dut_if.commit_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_ready: got %b want 1", dut_if.commit_valid); end
    set_in(1, 5'd7, 1, 4'd2, 32'h88, 1); #1;
    tests_run++; if (dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_commit_blocked: got %b want 0", dut_if.commit_valid); end
    tick(); #1;
    tests_run++; if (dut_if.count !== 4'd0 || dut_if.alloc_tag !== 4'd0 || dut_if.alloc_ready !== 1'b1) begin
      tests_failed++; $display("FAIL flush_ptrs: got count=%0d tag=%0d ready=%b want 0 0 1", dut_if.count, dut_if.alloc_tag, dut_if.alloc_ready); end
    for (int i = 0; i < SIZE; i++) begin
      tests_run++;
      if (dut_if.rdest[i].rdy !== 1'b0 || dut_if.rd_bus[i] !== 5'd0) begin
        tests_failed++; $display("FAIL flush_entry%0d: got rdy=%b rd=%0d want 0 0", i, dut_if.rdest[i].rdy, dut_if.rd_bus[i]);
      end
    end
  endtask

  task automatic test_stray_cdb();
    do_reset();
    set_in(1, 5'd3, 0, 4'd0, 32'd0, 0); tick();
    set_in(1, 5'd3, 0, 4'd0, 32'd0, 0); tick();
    set_in(0, 5'd0, 1, 4'd6, 32'hBAD0BAD0, 0); tick();
    set_in(0, 5'd0, 1, 4'd9, 32'hBAD1BAD1, 0); tick(); #1;
    tests_run++; if (dut_if.rdest[6].rdy !== 1'b0 || dut_if.rdest[6].data !== 32'd0 || dut_if.rd_bus[6] !== 5'd0) begin
      tests_failed++; $display("FAIL stray_entry6: got rdy=%b data=%h rd=%0d want 0 0 0", dut_if.rdest[6].rdy, dut_if.rdest[6].data, dut_if.rd_bus[6]); end
    tests_run++; if (dut_if.count !== 4'd2 || dut_if.commit_valid !== 1'b0 || dut_if.alloc_tag !== 4'd2) begin
      tests_failed++; $display("FAIL stray_state: got count=%0d cv=%b tag=%0d want 2 0 2", dut_if.count, dut_if.commit_valid, dut_if.alloc_tag); end
    set_in(0, 5'd0, 1, 4'd1, 32'hAAAA0001, 0); tick();
    set_in(0, 5'd0, 1, 4'd1, 32'hBBBB0002, 0); tick(); #1;
    tests_run++; if (dut_if.rdest[1].data !== 32'hAAAA0001 || dut_if.rdest[1].rdy !== 1'b1) begin
      tests_failed++; $display("FAIL stray_no_overwrite: got data=%h rdy=%b want aaaa0001 1", dut_if.rdest[1].data, dut_if.rdest[1].rdy); end
    tests_run++; if (dut_if.commit_valid !== 1'b0) begin tests_failed++; $display("FAIL stray_head_blocked: got %b want 0", dut_if.commit_valid); end
  endtask

  task automatic test_random();
    bit          av, cv, fl, exp_cv;
    logic [4:0]  rd;
    logic [3:0]  ct;
    logic [31:0] cd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      av = ($urandom_range(0, 99) < 60);
      rd = 5'($urandom_range(0, 31));
      cv = ($urandom_range(0, 99) < 55);
      if (q_tag.size() > 0 && $urandom_range(0, 99) < 75)
        ct = 4'(q_tag[$urandom_range(0, q_tag.size() - 1)]);
      else
        ct = 4'($urandom_range(0, 15));
      cd = $urandom();
      fl = ($urandom_range(0, 99) < 3);
      set_in(av, rd, cv, ct, cd, fl);
      #1;
      exp_cv = (q_tag.size() > 0) && m_ready[q_tag[0]] && !fl;
      tests_run++; if (dut_if.count !== 4'(q_tag.size())) begin tests_failed++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, dut_if.count, q_tag.size()); end
      tests_run++; if (dut_if.alloc_ready !== (q_tag.size() < SIZE)) begin tests_failed++; $display("FAIL rnd_alloc_ready c%0d: got %b want %b", c, dut_if.alloc_ready, q_tag.size() < SIZE); end
      tests_run++; if (dut_if.alloc_tag !== 4'(next_tag)) begin tests_failed++; $display("FAIL rnd_alloc_tag c%0d: got %0d want %0d", c, dut_if.alloc_tag, next_tag); end
      tests_run++; if (dut_if.commit_valid !== exp_cv) begin tests_failed++; $display("FAIL rnd_commit_valid c%0d: got %b want %b", c, dut_if.commit_valid, exp_cv); end
      if (exp_cv) begin
        tests_run++;
        if (dut_if.commit_tag !== 4'(q_tag[0]) || dut_if.commit_rd !== m_rd[q_tag[0]] || dut_if.commit_data !== m_data[q_tag[0]]) begin
          tests_failed++;
          $display("FAIL rnd_commit c%0d: got tag=%0d rd=%0d data=%h want %0d %0d %h", c, dut_if.commit_tag,
                   dut_if.commit_rd, dut_if.commit_data, q_tag[0], m_rd[q_tag[0]], m_data[q_tag[0]]);
        end
      end
      for (int i = 0; i < SIZE; i++) begin
        tests_run++;
        if (dut_if.rdest[i].tag !== 4'(i) || dut_if.rdest[i].rdy !== (m_busy[i] && m_ready[i]) ||
            dut_if.rdest[i].data !== m_data[i] || dut_if.rd_bus[i] !== (m_busy[i] ? m_rd[i] : 5'd0)) begin
          tests_failed++;
          $display("FAIL rnd_entry%0d c%0d: got tag=%0d rdy=%b data=%h rd=%0d want %0d %b %h %0d", i, c,
                   dut_if.rdest[i].tag, dut_if.rdest[i].rdy, dut_if.rdest[i].data, dut_if.rd_bus[i],
                   i, m_busy[i] && m_ready[i], m_data[i], m_busy[i] ? m_rd[i] : 5'd0);
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 5'd0, 0, 4'd0, 32'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_out_of_order();
    test_full_wrap();
    test_flush();
    test_stray_cdb();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
